// File: rtl/mpr121_multi_scanner.sv
// Initialises and polls up to N_DEV MPR121 touch controllers on a shared I2C bus through an
// external single-register i2c_controller, with NACK retry, per-device failover and a merged touch vector.
module mpr121_multi_scanner #(
  parameter int         N_DEV      = 1,
  parameter int         ELECTRODES = 12,
  parameter logic [6:0] BASE_ADDR  = 7'h5A,
  parameter logic [7:0] TOUCH_TH   = 8'h0F,
  parameter logic [7:0] REL_TH     = 8'h0A,
  parameter int         MAX_RETRY  = 3,
  parameter int         POLL_GAP   = 1000
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  output logic                          start_out,
  output logic [6:0]                    addr_out,
  output logic                          rw_out,
  output logic [7:0]                    cmd_out,
  output logic [7:0]                    wdata_out,
  input  logic [7:0]                    rdata_in,
  input  logic                          ack_in,
  input  logic                          done_in,
  output logic [N_DEV*ELECTRODES-1:0]   touch_status_out,
  output logic                          valid_out,
  output logic                          changed_out,
  output logic                          init_done_out,
  output logic [N_DEV-1:0]              dev_fail_out
);

  localparam int              DW        = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int              TW        = N_DEV * ELECTRODES;
  localparam logic [4:0]      LAST_TH   = 5'(2 * ELECTRODES - 1);
  localparam logic [7:0]      ECR_VAL   = {4'h0, 4'(ELECTRODES)};
  localparam logic [DW-1:0]   LAST_DEV  = DW'(N_DEV - 1);
  localparam logic [31:0]     GAP_LAST  = 32'(POLL_GAP - 1);
  localparam logic [7:0]      RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [N_DEV-1:0] ALL_FAIL = '1;

  typedef enum logic [3:0] {
    INIT_STOP, WR_TH, WR_ECR, CHK_ECR, NEXT_DEV,
    RD_LO, RD_HI, SWEEP_END, GAP, WAIT
  } state_t;

  state_t            state_q, state_d, ret_q, ret_d, poll_entry;
  logic [DW-1:0]     dev_q, dev_d;
  logic [4:0]        th_q, th_d;
  logic [7:0]        retry_q, retry_d;
  logic [7:0]        lo_q, lo_d;
  logic [TW-1:0]     shadow_q, shadow_d;
  logic [31:0]       gap_q, gap_d;

  logic              start_d, rw_d, valid_d, changed_d, init_done_d;
  logic [6:0]        addr_d;
  logic [7:0]        cmd_d, wdata_d;
  logic [TW-1:0]     touch_d;
  logic [N_DEV-1:0]  fail_d;

  logic              issue;
  logic              iss_rw;
  logic [7:0]        iss_cmd, iss_wdata;

  // With every device failed a sweep collapses to the SWEEP_END cycle alone.
  assign poll_entry = (dev_fail_out == ALL_FAIL) ? SWEEP_END : RD_LO;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    ret_d       = ret_q;
    dev_d       = dev_q;
    th_d        = th_q;
    retry_d     = retry_q;
    lo_d        = lo_q;
    shadow_d    = shadow_q;
    gap_d       = gap_q;
    start_d     = 1'b0;
    addr_d      = addr_out;
    rw_d        = rw_out;
    cmd_d       = cmd_out;
    wdata_d     = wdata_out;
    touch_d     = touch_status_out;
    valid_d     = 1'b0;
    changed_d   = 1'b0;
    init_done_d = init_done_out;
    fail_d      = dev_fail_out;
    issue       = 1'b0;
    iss_rw      = 1'b0;
    iss_cmd     = 8'h00;
    iss_wdata   = 8'h00;

    case (state_q)
      INIT_STOP: begin
        issue     = 1'b1;
        iss_cmd   = 8'h5E;
        iss_wdata = 8'h00;
      end
      WR_TH: begin
        issue     = 1'b1;
        iss_cmd   = 8'h41 + {3'b000, th_q};
        iss_wdata = th_q[0] ? REL_TH : TOUCH_TH;
      end
      WR_ECR: begin
        issue     = 1'b1;
        iss_cmd   = 8'h5E;
        iss_wdata = ECR_VAL;
      end
      CHK_ECR: begin
        issue   = 1'b1;
        iss_rw  = 1'b1;
        iss_cmd = 8'h5E;
      end
      NEXT_DEV: begin
        if (!init_done_out) begin
          if (dev_q == LAST_DEV) begin
            init_done_d = 1'b1;
            dev_d       = '0;
            state_d     = poll_entry;
          end else begin
            dev_d   = dev_q + DW'(1);
            state_d = INIT_STOP;
          end
        end else if (dev_q == LAST_DEV) begin
          dev_d   = '0;
          state_d = SWEEP_END;
        end else begin
          dev_d   = dev_q + DW'(1);
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        if (dev_fail_out[dev_q]) begin
          state_d = NEXT_DEV;
        end else begin
          issue   = 1'b1;
          iss_rw  = 1'b1;
          iss_cmd = 8'h00;
        end
      end
      RD_HI: begin
        issue   = 1'b1;
        iss_rw  = 1'b1;
        iss_cmd = 8'h01;
      end
      SWEEP_END: begin
        touch_d   = shadow_q;
        valid_d   = 1'b1;
        changed_d = (shadow_q != touch_status_out);
        gap_d     = '0;
        state_d   = (POLL_GAP == 0) ? poll_entry : GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = poll_entry;
        else                   gap_d   = gap_q + 32'd1;
      end
      WAIT: begin
        // done_in alongside our own start pulse can only be a leftover from before a reset.
        if (done_in && !start_out) begin
          if (ack_in && (ret_q != CHK_ECR || rdata_in == ECR_VAL)) begin
            retry_d = '0;
            case (ret_q)
              INIT_STOP: begin
                th_d    = '0;
                state_d = WR_TH;
              end
              WR_TH: begin
                if (th_q == LAST_TH) begin
                  state_d = WR_ECR;
                end else begin
                  th_d    = th_q + 5'd1;
                  state_d = WR_TH;
                end
              end
              WR_ECR: state_d = CHK_ECR;
              RD_LO: begin
                lo_d    = rdata_in;
                state_d = RD_HI;
              end
              RD_HI: begin
                shadow_d[dev_q*ELECTRODES +: ELECTRODES] = ELECTRODES'({rdata_in[3:0], lo_q});
                state_d = NEXT_DEV;
              end
              default: state_d = NEXT_DEV;
            endcase
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            state_d = ret_q;
          end else begin
            retry_d       = '0;
            fail_d[dev_q] = 1'b1;
            shadow_d[dev_q*ELECTRODES +: ELECTRODES] = '0;
            state_d       = NEXT_DEV;
          end
        end
      end
      default: state_d = INIT_STOP;
    endcase

    if (issue) begin
      start_d = 1'b1;
      addr_d  = BASE_ADDR + 7'(dev_q);
      rw_d    = iss_rw;
      cmd_d   = iss_cmd;
      wdata_d = iss_wdata;
      ret_d   = state_q;
      state_d = WAIT;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= INIT_STOP;
      ret_q            <= INIT_STOP;
      dev_q            <= '0;
      th_q             <= '0;
      retry_q          <= '0;
      lo_q             <= '0;
      shadow_q         <= '0;
      gap_q            <= '0;
      start_out        <= 1'b0;
      addr_out         <= '0;
      rw_out           <= 1'b0;
      cmd_out          <= '0;
      wdata_out        <= '0;
      touch_status_out <= '0;
      valid_out        <= 1'b0;
      changed_out      <= 1'b0;
      init_done_out    <= 1'b0;
      dev_fail_out     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q          <= state_d;
      ret_q            <= ret_d;
      dev_q            <= dev_d;
      th_q             <= th_d;
      retry_q          <= retry_d;
      lo_q             <= lo_d;
      shadow_q         <= shadow_d;
      gap_q            <= gap_d;
      start_out        <= start_d;
      addr_out         <= addr_d;
      rw_out           <= rw_d;
      cmd_out          <= cmd_d;
      wdata_out        <= wdata_d;
      touch_status_out <= touch_d;
      valid_out        <= valid_d;
      changed_out      <= changed_d;
      init_done_out    <= init_done_d;
      dev_fail_out     <= fail_d;
    end
  end

endmodule
